fifo_rr_write_arbiter: RTL

//   Round-robin write-port arbiter: shares one FIFO_Reg-style write interface (W_EN/DataIn/DIR)

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/rr_picker.sv | 46 ++++
 rtl/fifo_rr_write_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_arb_pkg                                                  |
// | Purpose  : Shared types and helpers for the round-robin FIFO write       |
// |            arbiter: FSM state encoding and owner-index width helper.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Width of an index that addresses num_req requesters (at least 1 bit).
  function automatic int owner_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_picker                                                     |
// | Purpose  : Combinational round-robin search. Scans req starting at       |
// |            'start' and wrapping modulo NUM_REQ; the first set bit wins.  |
// | Ports    : req    in  NUM_REQ  request vector                            |
// |            start  in  IDX_W    first index examined                      |
// |            winner out IDX_W    index of winning requester                |
// |            found  out 1        at least one request set                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  // Walk from the farthest offset back to offset 0 so the closest set
  // request (smallest offset from start) overwrites any earlier match.
  // start < NUM_REQ and k < NUM_REQ, so one conditional subtraction
  // performs the modulo.
  always_comb begin
    logic [IDX_W:0] w_idx;
    winner = '0;
    found  = 1'b0;
    w_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, start} + (IDX_W + 1)'(k);
      if (w_idx >= (IDX_W + 1)'(NUM_REQ)) begin
        w_idx = w_idx - (IDX_W + 1)'(NUM_REQ);
      end
      if (req[w_idx[IDX_W-1:0]]) begin
        winner = w_idx[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_rr_write_arbiter                                         |
// | Purpose  : Round-robin arbiter sharing one FIFO write port among         |
// |            NUM_REQ producers. One producer owns the port for a burst of  |
// |            up to BURST words; FIFO back-pressure (fifo_dir=0) stalls the |
// |            burst, and ownership rotates fairly on exit.                  |
// | Ports    : clk        in  1              clock, posedge                  |
// |            rst_n      in  1              async active-low reset          |
// |            en         in  1              global enable / freeze          |
// |            req        in  NUM_REQ        producer valid                  |
// |            req_data   in  NUM_REQ*WIDTH  producer words, slice per req   |
// |            gnt        out NUM_REQ        registered one-hot grant        |
// |            owner      out log2(NUM_REQ)  granted producer index          |
// |            busy       out 1              grant held                      |
// |            fifo_dir   in  1              FIFO ready                      |
// |            fifo_w_en  out 1              FIFO write strobe (comb)        |
// |            fifo_data  out WIDTH          FIFO write data (comb)          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fifo_rr_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int BURST   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  input  logic                       fifo_dir,
  output logic                       fifo_w_en,
  output logic [WIDTH-1:0]           fifo_data
);

  localparam int c_idx_w = owner_w(NUM_REQ);
  localparam int c_cnt_w = $clog2(BURST) + 1;

  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BURST - 1);
  localparam logic [c_idx_w-1:0] c_top_idx   = c_idx_w'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] c_gnt_one   = NUM_REQ'(1);

  arb_state_t           r_state,      w_nxt_state;
  logic [NUM_REQ-1:0]   r_gnt,        w_nxt_gnt;
  logic [c_idx_w-1:0]   r_owner,      w_nxt_owner;
  logic [c_cnt_w-1:0]   r_beat_cnt,   w_nxt_beat_cnt;
  logic [c_idx_w-1:0]   r_last_owner, w_nxt_last_owner;

  logic [c_idx_w-1:0]   w_start;
  logic [c_idx_w-1:0]   w_winner;
  logic                 w_found;
  logic                 w_exit;

  // Search begins one past the most recent winner. While granted, the
  // current owner equals last_owner, so it is examined last and is only
  // re-granted when nobody else is requesting.
  assign w_start = (r_last_owner == c_top_idx) ? '0 : r_last_owner + c_idx_w'(1);

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_idx_w)
  ) u_rr_picker (
    .req    (req),
    .start  (w_start),
    .winner (w_winner),
    .found  (w_found)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_owner      <= '0;
      r_beat_cnt   <= '0;
      r_last_owner <= c_top_idx;
    end else if (en) begin
      r_state      <= w_nxt_state;
      r_gnt        <= w_nxt_gnt;
      r_owner      <= w_nxt_owner;
      r_beat_cnt   <= w_nxt_beat_cnt;
      r_last_owner <= w_nxt_last_owner;
    end
  end

  // Next-state logic.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_gnt        = r_gnt;
    w_nxt_owner      = r_owner;
    w_nxt_beat_cnt   = r_beat_cnt;
    w_nxt_last_owner = r_last_owner;
    w_exit           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_nxt_state      = ST_GRANT;
          w_nxt_gnt        = c_gnt_one << w_winner;
          w_nxt_owner      = w_winner;
          w_nxt_beat_cnt   = '0;
          w_nxt_last_owner = w_winner;
        end
      end

      ST_GRANT: begin
        if (fifo_w_en) begin
          w_nxt_beat_cnt = r_beat_cnt + c_cnt_w'(1);
        end
        // A stalled FIFO produces no accepted word, so the burst limit
        // cannot trigger an exit while fifo_dir is low.
        w_exit = !req[r_owner] || (fifo_w_en && (r_beat_cnt == c_last_beat));
        if (w_exit) begin
          if (w_found) begin
            w_nxt_gnt        = c_gnt_one << w_winner;
            w_nxt_owner      = w_winner;
            w_nxt_beat_cnt   = '0;
            w_nxt_last_owner = w_winner;
          end else begin
            w_nxt_state    = ST_IDLE;
            w_nxt_gnt      = '0;
            w_nxt_beat_cnt = '0;
          end
        end
      end

      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_gnt   = '0;
      end
    endcase
  end

  // Outputs. The write strobe is qualified by the live request so a
  // producer that withdraws mid-grant never has a stale word written.
  always_comb begin
    busy      = (r_state == ST_GRANT);
    fifo_w_en = en && fifo_dir && (|(r_gnt & req));
    fifo_data = req_data[r_owner*WIDTH +: WIDTH];
  end

  assign gnt   = r_gnt;
  assign owner = r_owner;

endmodule
`default_nettype wire
